servo_cmd_exec: RTL
===================

# servo_cmd_exec

Consumes the 10-bit `instruction` word assembled by the serial MBED receiver and turns it into a servo PWM drive signal. It sits directly downstream of the receiver. It brings the instruction into the system clock domain, detects new instructions, and decodes them into target position, slew rate and enable. It then generates a glitch-free 50 Hz PWM output with slew-limited position updates.

## Interface
Parameters:
- `TICK_DIV`, 50: clk cycles per 1 µs tick (50 MHz clk).
- `PERIOD_US`, 20000: PWM period in µs.
- `MIN_US`, 1000: pulse width at position 0.
- `STEP_US`, 4: pulse µs per position LSB; position 255 gives 2020 µs.

Ports:
- `clk`, in, 1: system clock. Single clock domain. Reset is synchronous and active-high.
- `reset`, in, 1: synchronous, active-high. All state takes reset values on the clk edge where it is sampled high.
- `instruction`, in, 10: level-held word from the receiver. It is asynchronous to `clk`.
- `pwm`, out, 1: servo drive. Reset 0.
- `position`, out, 8: current (slewed) position. Reset 128.
- `enabled`, out, 1: output stage active. Reset 0.
- `busy`, out, 1: `position` ≠ target. Reset 0.
- `instr_ack`, out, 1: one-cycle pulse when an instruction is accepted. Reset 0.

## Operation
- Instruction format: bits [9:8] opcode, bits [7:0] operand.
  - 00 NOP: no effect; still acked.
  - 01 SET_POS: target ← operand.
  - 10 SET_SLEW: slew ← operand. Slew 0 freezes position at its current value.
  - 11 CTRL: operand[0]=1 requests enable, 0 requests disable. operand[7:1] is ignored.
- Input capture:
  - Two-flop synchronizer (s1, s2), then history register s3.
  - Accept when s2 == s3 and s2 ≠ last_accepted.
  - On accept, last_accepted ← s2 and `instr_ack` pulses.
  - A new word identical to the last accepted one is not re-executed; this is intended.
  - Synchronizer, s3 and last_accepted all reset to 0. An all-zero word after reset is therefore never acked.
- Register defaults: target reset 128, slew reset 255.
- Period engine:
  - Prescaler counts 0..TICK_DIV-1 and emits a tick.
  - us_cnt counts 0..PERIOD_US-1 on ticks and wraps to 0.
- Period start (tick with us_cnt == PERIOD_US-1), in this order:
  1. Slew update. If |target − position| ≤ slew, position ← target. Otherwise position moves toward target by slew. Use 9-bit signed difference; no wrap-around past 0 or 255.
  2. pulse_us ← MIN_US + position×STEP_US, computed from the updated position; 12 bits minimum.
  3. enabled ← pending enable request.
- `pwm` = enabled && us_cnt < pulse_us, registered.
- `busy` = (position ≠ target), registered.
- Simultaneous events:
  - An instruction accepted on the period-start cycle takes effect at the next period start. Decode writes the target/slew/enable registers; the period engine samples their previous values.
  - Several SET_POS within one period: only the last one matters.

## Timing
- Latency: if `instruction` settles before clk edge k, `instr_ack` is high in the cycle after edge k+3. Decoded registers update on that same edge.
- Bit skew across the crossing is tolerated. The word is only accepted after two equal consecutive synchronized samples.
- Upstream must hold each word for at least 4 clk cycles. The receiver's word rate is far slower than this.
- Pulse width and enable change only at period boundaries. No runt or stretched pulses.
- Output stays low for the whole period after a disable takes effect.
- First period after reset: `pwm` is low because enabled=0. us_cnt and prescaler start from 0.
- Reset mid-pulse: `pwm` goes to 0 on the reset edge. All registers return to reset values, and the pending enable request clears to 0.

## Structure
- Shared package `servo_pkg`:
  - opcode constants OP_NOP, OP_SET_POS, OP_SET_SLEW, OP_CTRL
  - INSTR_W=10
  - POS_RESET=128
  - SLEW_RESET=255
- Sub-module `instr_sync`: the 2-flop synchronizer, stability check, new-word detect and `instr_ack` generation. It outputs the accepted word plus a valid pulse.
- Top level holds the decode registers, prescaler, period counter, slew logic and PWM comparator.

## Test plan
- Reset, then CTRL enable (0x301), then wait 2 periods. Expect `instr_ack` once. From the second period, `pwm` high for 1512 µs (position 128) out of 20000 µs.
- SET_POS 0x1FF with slew 255. Expect the next period's pulse to be 2020 µs, `position`=255, and `busy` to fall at that period start.
- SET_SLEW 0x210, then SET_POS 0x100 starting from 128. Expect position to step 112, 96, …, 0 (8 periods), with `busy` high until position reaches 0.
- Drive skewed bit transitions: change individual bits one cycle apart, then hold. Expect exactly one `instr_ack`, for the final word. Re-presenting the same word gives no ack.
- CTRL disable (0x300) asserted mid-pulse. Expect the current pulse to complete at full width, then `pwm` low from the next period start and `enabled`=0.
- Assert `reset` mid-pulse while slewing. On that edge expect `pwm`=0, `position`=128, `enabled`=0, `busy`=0. No ack for the held word until it changes.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the servo command executor: instruction layout,
// opcode values, register reset values and the slew-step helper.
package servo_pkg;

    localparam int         INSTR_W    = 10;
    localparam logic [7:0] POS_RESET  = 8'd128;
    localparam logic [7:0] SLEW_RESET = 8'd255;

    typedef enum logic [1:0] {
        OP_NOP      = 2'b00,
        OP_SET_POS  = 2'b01,
        OP_SET_SLEW = 2'b10,
        OP_CTRL     = 2'b11
    } opcode_e;

    typedef struct packed {
        opcode_e    op;
        logic [7:0] operand;
    } instr_t;

    // Move pos toward tgt by at most rate; lands exactly on tgt when close enough,
    // so the result never wraps past 0 or 255.
    function automatic logic [7:0] slew_step(input logic [7:0] pos,
                                             input logic [7:0] tgt,
                                             input logic [7:0] rate);
        logic signed [8:0] diff;
        logic [8:0]        mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, pos});
        mag  = diff[8] ? -diff : diff;
        if (mag <= {1'b0, rate})
            return tgt;
        else if (diff[8])
            return pos - rate;
        else
            return pos + rate;
    endfunction

endpackage

// File: rtl/instr_sync.sv
// Brings the level-held instruction word into the clk domain and flags each
// new, stable word exactly once.
module instr_sync
    import servo_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] acc_word,
    output logic               acc_valid,
    output logic               instr_ack
);

    logic [INSTR_W-1:0] s1, s2, s3, last_accepted;

    // A word is taken once two consecutive synchronized samples agree, which
    // filters out bit skew across the crossing; repeats of the last word are ignored.
    assign acc_valid = (s2 == s3) && (s2 != last_accepted);
    assign acc_word  = s2;

    // Synchronizer chain, history register and acceptance bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1            <= '0;
            s2            <= '0;
            s3            <= '0;
            last_accepted <= '0;
            instr_ack     <= 1'b0;
        end else begin
            s1        <= instruction;
            s2        <= s1;
            s3        <= s2;
            instr_ack <= acc_valid;
            if (acc_valid)
                last_accepted <= s2;
        end
    end

endmodule

// File: rtl/servo_cmd_exec.sv
// Servo command executor: decodes accepted instructions into target, slew and
// enable, and drives a period-aligned, slew-limited PWM output.
module servo_cmd_exec
    import servo_pkg::*;
#(
    parameter int TICK_DIV  = 50,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 1000,
    parameter int STEP_US   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    output logic               pwm,
    output logic [7:0]         position,
    output logic               enabled,
    output logic               busy,
    output logic               instr_ack
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = ($clog2(PERIOD_US) > 12) ? $clog2(PERIOD_US) : 12;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD_US - 1);

    function automatic logic [CW-1:0] pulse_of(input logic [7:0] p);
        return CW'(MIN_US + int'(p) * STEP_US);
    endfunction

    logic [INSTR_W-1:0] acc_word;
    logic               acc_valid;
    instr_t             acc;
    logic [7:0]         target, slew, pos_next;
    logic               en_req;
    logic [PW-1:0]      pre;
    logic [CW-1:0]      us_cnt, pulse_us;
    logic               tick, period_start;

    instr_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .acc_word    (acc_word),
        .acc_valid   (acc_valid),
        .instr_ack   (instr_ack)
    );

    assign acc          = instr_t'(acc_word);
    assign tick         = (pre == PRE_MAX);
    assign period_start = tick && (us_cnt == CNT_MAX);
    assign pos_next     = slew_step(position, target, slew);

    // Decode registers; the period engine samples their pre-edge values, so a
    // word accepted on a period-start cycle lands in the following period.
    always_ff @(posedge clk) begin
        if (reset) begin
            target <= POS_RESET;
            slew   <= SLEW_RESET;
            en_req <= 1'b0;
        end else if (acc_valid) begin
            case (acc.op)
                OP_SET_POS:  target <= acc.operand;
                OP_SET_SLEW: slew   <= acc.operand;
                OP_CTRL:     en_req <= acc.operand[0];
                default:     ;
            endcase
        end
    end

    // Period engine: microsecond prescaler, period counter, and the
    // once-per-period update of position, pulse width and enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre      <= '0;
            us_cnt   <= '0;
            position <= POS_RESET;
            pulse_us <= pulse_of(POS_RESET);
            enabled  <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick)
                us_cnt <= (us_cnt == CNT_MAX) ? '0 : us_cnt + 1'b1;
            if (period_start) begin
                position <= pos_next;
                pulse_us <= pulse_of(pos_next);
                enabled  <= en_req;
            end
        end
    end

    // Registered outputs; width and enable only move at period boundaries,
    // so each pulse is either full width or absent.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm  <= 1'b0;
            busy <= 1'b0;
        end else begin
            pwm  <= enabled && (us_cnt < pulse_us);
            busy <= (position != target);
        end
    end

endmodule
